fp16_mul_arbiter: RTL and testbench
===================================

Name: fp16_mul_arbiter

Overview:
- Shares one 2-stage half-precision multiplier (fp16: sign/5-bit exponent/10-bit fraction) among NREQ requesters, e.g. neuron weight×input lanes.
- Each cycle, grants at most one requester by round-robin and drives the multiplier operands and enable.
- Tracks the in-flight requester ID through a latency-matched tag pipeline and returns each product to the requester that issued it.
- Sits between the neuron accumulator lanes and the single multiplier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LATENCY, 2, cycles from the multiplier enable being sampled to its product being valid on mul_out.
- IDW, 2, tag width; must equal clog2(NREQ).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operand-pair valid
- req_a  in  16*NREQ  fp16 operand A; requester i uses bits [16i+15:16i]
- req_b  in  16*NREQ  fp16 operand B, same packing as req_a
- req_ready  out  NREQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
- mul_a  out  16  operand A to the multiplier
- mul_b  out  16  operand B to the multiplier
- mul_en  out  1  multiplier enable
- mul_out  in  16  multiplier product
- rsp_valid  out  NREQ  one-hot: product for requester i is valid this cycle
- rsp_data  out  16  product, shared by all requesters
- busy  out  1  at least one product in flight

Behaviour:
- One clock, clk. Reset is rst: synchronous, active-high.
- Reset values:
  - rsp_valid=0, rsp_data=0, busy=0.
  - Round-robin pointer=0.
  - Tag pipeline valid bits all 0.
  - req_ready and mul_en are 0 while rst=1.
- Grant (combinational from req_valid and the pointer):
  - Search starts at the pointer and wraps modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1.
  - No valid request: req_ready=0 and mul_en=0.
- Issue, in the grant cycle t:
  - mul_a/mul_b = granted requester's operands; mul_en=1.
  - No grant: mul_a/mul_b = 0.
- Pointer update: at the clock edge after a grant to i, the pointer becomes (i+1) mod NREQ. With no grant, the pointer holds.
- Requester rule: a requester must hold req_valid and its operands stable until granted. The arbiter never drops an accepted request.
- Throughput: one issue per cycle; no stall.
- Tag pipeline:
  - LATENCY stages of {valid, id}; stage 0 loads {mul_en, granted id} at the edge ending cycle t.
  - At the edge ending cycle t+LATENCY, the tail stage is valid, so the block registers rsp_data = mul_out and rsp_valid = one-hot(tail id).
  - A product issued in cycle t therefore appears on rsp_valid/rsp_data in cycle t+LATENCY+1 and lasts exactly 1 cycle.
- Responses:
  - rsp_valid is 0 in cycles with no response; rsp_data holds its last value.
  - There is no response backpressure; requesters must always sink rsp_valid.
- Ordering: responses leave in issue order. Back-to-back issues produce back-to-back responses.
- The multiplier's ready output is not used. Completion is derived only from the tag pipeline.
- busy = OR of all tag-stage valid bits, plus a registered-pending flag covering the cycle in which the tail result is captured.
- Reset mid-operation:
  - All in-flight tags are discarded, so no rsp_valid pulse for them.
  - The pointer returns to 0.
  - The first grant after reset deasserts goes to the lowest valid index.
- Simultaneous events: a new grant and a response in the same cycle are independent and both occur.
- Width rules: operands and results pass through unmodified. The block does no fp16 arithmetic and no special-case handling.

Decomposition:
- Shared package:
  - FP16_W=16.
  - Default NREQ and LATENCY.
  - Function clog2.
  - Typedef of the tag struct {valid, id}.
- One sub-module, rr_grant: combinational round-robin priority pick with one-hot grant and encoded id. The tag pipeline and response register stay in the top module.

Test Plan:
- Single issue: req_valid=0001, a=0x3C00, b=0x4000 in cycle 0 → req_ready=0001, mul_en=1 in cycle 0; rsp_valid=0001, rsp_data=0x4000 in cycle 3 only.
- All-contend: req_valid=1111 held, operands 0x4000×0x4200 (lane 0) and 0x3E00×0x3E00 (lane 1), others 0x3C00×0x3C00 → grants 0001, 0010, 0100, 1000 in cycles 0–3; responses 0x4600, 0x4080, 0x3C00, 0x3C00 on lanes 0–3 in cycles 3–6.
- Fairness and wrap: grant lane 3, then raise lanes 0 and 3 together → lane 0 is granted next, then lane 3; the pointer wraps from 3 to 0.
- Streaming from one lane: lane 2 valid for 5 consecutive cycles, others idle → 5 consecutive grants to lane 2; 5 consecutive rsp_valid=0100; busy high from cycle 1 through cycle 7.
- Reset mid-flight: issue lanes 0 and 1, assert rst in cycle 2 for 1 cycle → no rsp_valid pulses afterwards; busy=0 after reset; next simultaneous request from lanes 1 and 3 is granted to lane 1.
- Idle: req_valid=0 for 10 cycles → mul_en=0, mul_a=0, rsp_valid=0, pointer unchanged.

Source files
------------

// File: rtl/fp16_mul_arbiter_pkg.sv
// rtl/fp16_mul_arbiter_pkg.sv - shared constants, tag type and helpers for the fp16 multiplier arbiter
package fp16_mul_arbiter_pkg;
  localparam int FP16_W      = 16;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_LATENCY = 2;
  // Tag id is sized for the largest supported requester count (8).
  localparam int MAX_IDW     = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef struct packed {
    logic               valid;
    logic [MAX_IDW-1:0] id;
  } tag_t;
endpackage

// File: rtl/fp16_mul_arbiter_if.sv
// rtl/fp16_mul_arbiter_if.sv - requester and multiplier signal bundle for the fp16 multiplier arbiter
interface fp16_mul_arbiter_if
  import fp16_mul_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) ();
  logic [NREQ-1:0]        req_valid;
  logic [FP16_W*NREQ-1:0] req_a;
  logic [FP16_W*NREQ-1:0] req_b;
  logic [NREQ-1:0]        req_ready;
  logic [FP16_W-1:0]      mul_a;
  logic [FP16_W-1:0]      mul_b;
  logic                   mul_en;
  logic [FP16_W-1:0]      mul_out;
  logic [NREQ-1:0]        rsp_valid;
  logic [FP16_W-1:0]      rsp_data;
  logic                   busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_out,
    output req_ready, mul_a, mul_b, mul_en, rsp_valid, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_out,
    input  req_ready, mul_a, mul_b, mul_en, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/fp16_mul_arbiter_rr_grant.sv
// rtl/fp16_mul_arbiter_rr_grant.sv - combinational round-robin pick starting at the pointer, one-hot plus encoded id
module fp16_mul_arbiter_rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] reqValid,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grantId,
  output logic            anyGrant
);
  int idx;

  always_comb begin
    grant    = '0;
    grantId  = '0;
    anyGrant = 1'b0;
    idx      = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!anyGrant && reqValid[idx]) begin
        anyGrant     = 1'b1;
        grant[idx]   = 1'b1;
        grantId      = IDW'(idx);
      end
    end
  end
endmodule

// File: rtl/fp16_mul_arbiter.sv
// rtl/fp16_mul_arbiter.sv - shares one pipelined fp16 multiplier among NREQ requesters
// and routes each product back through a latency-matched tag pipeline.
module fp16_mul_arbiter
  import fp16_mul_arbiter_pkg::*;
#(
  parameter int NREQ    = DEF_NREQ,
  parameter int LATENCY = DEF_LATENCY,
  parameter int IDW     = 2
) (
  input logic               clk,
  input logic               rst,
  fp16_mul_arbiter_if.slave bus
);
  if (IDW != clog2(NREQ)) begin : gIdwCheck
    $error("IDW must equal clog2(NREQ)");
  end

  logic [IDW-1:0]    ptrQ;
  logic [IDW-1:0]    grantId;
  logic [NREQ-1:0]   grantVec;
  logic              anyGrant;
  logic              issue;
  tag_t              tagQ [LATENCY];
  tag_t              tail;
  logic              pendQ;
  logic              inFlight;
  logic [NREQ-1:0]   rspValidQ;
  logic [FP16_W-1:0] rspDataQ;

  fp16_mul_arbiter_rr_grant #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) uGrant (
    .reqValid(bus.req_valid),
    .ptr     (ptrQ),
    .grant   (grantVec),
    .grantId (grantId),
    .anyGrant(anyGrant)
  );

  // Nothing is granted while reset is held, so no request can be lost to it.
  assign issue         = anyGrant & ~rst;
  assign bus.req_ready = issue ? grantVec : '0;
  assign bus.mul_en    = issue;
  assign bus.mul_a     = issue ? bus.req_a[int'(grantId)*FP16_W +: FP16_W] : '0;
  assign bus.mul_b     = issue ? bus.req_b[int'(grantId)*FP16_W +: FP16_W] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptrQ <= '0;
    end else if (issue) begin
      ptrQ <= (grantId == IDW'(NREQ - 1)) ? '0 : grantId + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LATENCY; s++) tagQ[s] <= '0;
    end else begin
      tagQ[0] <= '{valid: issue, id: MAX_IDW'(grantId)};
      for (int s = 1; s < LATENCY; s++) tagQ[s] <= tagQ[s-1];
    end
  end

  assign tail = tagQ[LATENCY-1];

  // The tail tag lines up with the product on mul_out, so it is captured directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      rspValidQ <= '0;
      rspDataQ  <= '0;
      pendQ     <= 1'b0;
    end else begin
      pendQ     <= tail.valid;
      rspValidQ <= tail.valid ? (NREQ'(1) << tail.id) : '0;
      if (tail.valid) rspDataQ <= bus.mul_out;
    end
  end

  always_comb begin
    inFlight = pendQ;
    for (int s = 0; s < LATENCY; s++) inFlight = inFlight | tagQ[s].valid;
  end

  assign bus.rsp_valid = rspValidQ;
  assign bus.rsp_data  = rspDataQ;
  assign bus.busy      = inFlight;
endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb/tb_fp16_mul_arbiter.sv - self-checking bench for fp16_mul_arbiter with a behavioural multiplier and reference model
module tb_fp16_mul_arbiter;
  localparam int NREQ = 4, LATENCY = 2, IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0, errors = 0;

  fp16_mul_arbiter_if #(.NREQ(NREQ)) bus ();
  fp16_mul_arbiter #(.NREQ(NREQ), .LATENCY(LATENCY), .IDW(IDW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Normal-range fp16 product with truncation; stands in for the shared multiplier.
  function automatic logic [15:0] fpmul(logic [15:0] a, logic [15:0] b);
    logic [21:0] p;
    int e;
    p = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) return {a[15] ^ b[15], 5'(e + 1), p[20:11]};
    return {a[15] ^ b[15], 5'(e), p[19:10]};
  endfunction

  logic [15:0] mulPipe [LATENCY];
  always @(posedge clk) begin
    mulPipe[0] <= fpmul(bus.mul_a, bus.mul_b);
    for (int s = 1; s < LATENCY; s++) mulPipe[s] <= mulPipe[s-1];
  end
  assign bus.mul_out = mulPipe[LATENCY-1];

  logic [NREQ-1:0] vld;
  logic [15:0] opA [NREQ];
  logic [15:0] opB [NREQ];

  // Reference model: pointer, responses keyed by the cycle they must appear in.
  int cyc = 0, mPtr = 0;
  logic [15:0] mLast = 16'h0;
  int dueLane [int];
  logic [15:0] dueData [int];
  int expLane;
  logic [NREQ-1:0] expReady, expRspV;
  logic [15:0] expA, expB, expRspD;
  logic expBusy;

  function automatic int rr_pick(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++) if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  function automatic void compute_expect();
    expLane = rst ? -1 : rr_pick(bus.req_valid, mPtr);
    expReady = '0; expA = 16'h0; expB = 16'h0;
    if (expLane >= 0) begin
      expReady = NREQ'(1) << expLane;
      expA = opA[expLane];
      expB = opB[expLane];
    end
    expRspV = dueLane.exists(cyc) ? NREQ'(1) << dueLane[cyc] : '0;
    expRspD = dueLane.exists(cyc) ? dueData[cyc] : mLast;
    expBusy = 1'b0;
    for (int d = cyc; d <= cyc + LATENCY; d++) if (dueLane.exists(d)) expBusy = 1'b1;
  endfunction

  task automatic drive_bus();
    bus.req_valid = vld;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[i*16 +: 16] = opA[i];
      bus.req_b[i*16 +: 16] = opB[i];
    end
  endtask

  task automatic advance();
    compute_expect();
    @(posedge clk);
    if (rst) begin
      dueLane.delete(); dueData.delete(); mPtr = 0; mLast = 16'h0;
    end else begin
      mLast = expRspD;
      if (expLane >= 0) begin
        dueLane[cyc + LATENCY + 1] = expLane;
        dueData[cyc + LATENCY + 1] = fpmul(opA[expLane], opB[expLane]);
        mPtr = (expLane + 1) % NREQ;
      end
    end
    cyc++;
    #1;
  endtask

  function automatic logic [15:0] rand_fp();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(10, 20)), 10'($urandom)};
  endfunction

  task automatic pulse_reset();
    rst = 1'b1; vld = '0; drive_bus();
    advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = '0; drive_bus();
    advance();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin vld = 4'b1010; drive_bus(); end
      @(negedge clk);
      checks++; if (bus.req_ready !== 4'b0000 || bus.mul_en !== 1'b0) begin
        errors++; $display("FAIL reset_grant ready=%b en=%b required 0000/0", bus.req_ready, bus.mul_en); end
      checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 16'h0) begin
        errors++; $display("FAIL reset_rsp valid=%b data=%h required 0000/0000", bus.rsp_valid, bus.rsp_data); end
      checks++; if (bus.busy !== 1'b0) begin
        errors++; $display("FAIL reset_busy got %b required 0", bus.busy); end
      advance();
    end
    rst = 1'b0; vld = '0; drive_bus();
  endtask

  task automatic test_single();
    opA[0] = 16'h3C00; opB[0] = 16'h4000; vld = 4'b0001; drive_bus();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        checks++; if (bus.req_ready !== 4'b0001 || bus.mul_en !== 1'b1 || bus.mul_a !== 16'h3C00 || bus.mul_b !== 16'h4000) begin
          errors++; $display("FAIL single_issue ready=%b en=%b a=%h b=%h required 0001/1/3c00/4000", bus.req_ready, bus.mul_en, bus.mul_a, bus.mul_b); end
      end
      checks++; if (bus.rsp_valid !== ((k == 3) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL single_rsp_valid cycle %0d got %b", k, bus.rsp_valid); end
      if (k == 3) begin
        checks++; if (bus.rsp_data !== 16'h4000) begin
          errors++; $display("FAIL single_rsp_data got %h required 4000", bus.rsp_data); end
      end
      checks++; if (bus.busy !== (k >= 1 && k <= 3)) begin
        errors++; $display("FAIL single_busy cycle %0d got %b", k, bus.busy); end
      advance();
      vld = '0; drive_bus();
    end
  endtask

  task automatic test_all_contend();
    logic [15:0] expData [4];
    logic [3:0] expR, expV;
    expData[0] = 16'h4600; expData[1] = 16'h4080; expData[2] = 16'h3C00; expData[3] = 16'h3C00;
    pulse_reset();
    opA[0] = 16'h4000; opB[0] = 16'h4200; opA[1] = 16'h3E00; opB[1] = 16'h3E00;
    opA[2] = 16'h3C00; opB[2] = 16'h3C00; opA[3] = 16'h3C00; opB[3] = 16'h3C00;
    vld = 4'b1111; drive_bus();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      expR = (k < 4) ? 4'(1 << k) : 4'b0000;
      expV = (k >= 3 && k <= 6) ? 4'(1 << (k - 3)) : 4'b0000;
      checks++; if (bus.req_ready !== expR) begin
        errors++; $display("FAIL contend_grant cycle %0d got %b required %b", k, bus.req_ready, expR); end
      checks++; if (bus.rsp_valid !== expV) begin
        errors++; $display("FAIL contend_rsp_valid cycle %0d got %b required %b", k, bus.rsp_valid, expV); end
      if (k >= 3 && k <= 6) begin
        checks++; if (bus.rsp_data !== expData[k-3]) begin
          errors++; $display("FAIL contend_rsp_data cycle %0d got %h required %h", k, bus.rsp_data, expData[k-3]); end
      end
      advance();
      if (k < 4) begin vld[k] = 1'b0; drive_bus(); end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] reqs [3];
    logic [3:0] grants [3];
    reqs[0] = 4'b1000; reqs[1] = 4'b1001; reqs[2] = 4'b1000;
    grants[0] = 4'b1000; grants[1] = 4'b0001; grants[2] = 4'b1000;
    opA[0] = rand_fp(); opB[0] = rand_fp(); opA[3] = rand_fp(); opB[3] = rand_fp();
    for (int k = 0; k < 7; k++) begin
      vld = (k < 3) ? reqs[k] : 4'b0000; drive_bus();
      @(negedge clk); compute_expect();
      if (k < 3) begin
        checks++; if (bus.req_ready !== grants[k]) begin
          errors++; $display("FAIL fair_grant cycle %0d got %b required %b", k, bus.req_ready, grants[k]); end
      end
      checks++; if (bus.rsp_valid !== expRspV || bus.rsp_data !== expRspD) begin
        errors++; $display("FAIL fair_rsp cycle %0d got %b/%h required %b/%h", k, bus.rsp_valid, bus.rsp_data, expRspV, expRspD); end
      advance();
      if (k == 0) begin opA[3] = rand_fp(); opB[3] = rand_fp(); end
    end
  endtask

  task automatic test_stream();
    opA[2] = rand_fp(); opB[2] = rand_fp();
    for (int k = 0; k < 10; k++) begin
      vld = (k < 5) ? 4'b0100 : 4'b0000; drive_bus();
      @(negedge clk); compute_expect();
      checks++; if (bus.req_ready !== ((k < 5) ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL stream_grant cycle %0d got %b", k, bus.req_ready); end
      checks++; if (bus.rsp_valid !== ((k >= 3 && k <= 7) ? 4'b0100 : 4'b0000)) begin
        errors++; $display("FAIL stream_rsp_valid cycle %0d got %b", k, bus.rsp_valid); end
      checks++; if (bus.rsp_data !== expRspD) begin
        errors++; $display("FAIL stream_rsp_data cycle %0d got %h required %h", k, bus.rsp_data, expRspD); end
      checks++; if (bus.busy !== (k >= 1 && k <= 7)) begin
        errors++; $display("FAIL stream_busy cycle %0d got %b", k, bus.busy); end
      advance();
      opA[2] = rand_fp(); opB[2] = rand_fp();
    end
  endtask

  task automatic test_reset_midflight();
    opA[0] = rand_fp(); opB[0] = rand_fp(); opA[1] = rand_fp(); opB[1] = rand_fp();
    opA[3] = rand_fp(); opB[3] = rand_fp();
    vld = 4'b0011; drive_bus();
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0001) begin
      errors++; $display("FAIL midrst_grant0 got %b required 0001", bus.req_ready); end
    advance(); vld[0] = 1'b0; drive_bus();
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL midrst_grant1 got %b required 0010", bus.req_ready); end
    advance();
    rst = 1'b1; vld = 4'b0100; drive_bus();
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0000 || bus.mul_en !== 1'b0) begin
      errors++; $display("FAIL midrst_gated ready=%b en=%b required 0000/0", bus.req_ready, bus.mul_en); end
    advance();
    rst = 1'b0; vld = '0; drive_bus();
    for (int k = 3; k < 7; k++) begin
      @(negedge clk);
      checks++; if (bus.rsp_valid !== 4'b0000 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL midrst_flushed cycle %0d valid=%b busy=%b required 0000/0", k, bus.rsp_valid, bus.busy); end
      advance();
    end
    vld = 4'b1010; drive_bus();
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL midrst_first_grant got %b required 0010", bus.req_ready); end
    advance(); vld[1] = 1'b0; drive_bus();
    advance(); vld = '0; drive_bus();
    for (int k = 0; k < 4; k++) advance();
  endtask

  task automatic test_idle();
    opA[1] = rand_fp(); opB[1] = rand_fp();
    vld = 4'b0010; drive_bus();
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0010) begin
      errors++; $display("FAIL idle_setup_grant got %b required 0010", bus.req_ready); end
    advance(); vld = '0; drive_bus();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); compute_expect();
      checks++; if (bus.mul_en !== 1'b0 || bus.mul_a !== 16'h0 || bus.mul_b !== 16'h0 || bus.req_ready !== 4'b0000) begin
        errors++; $display("FAIL idle_issue cycle %0d en=%b a=%h b=%h ready=%b required 0/0/0/0", k, bus.mul_en, bus.mul_a, bus.mul_b, bus.req_ready); end
      checks++; if (bus.rsp_valid !== expRspV || bus.rsp_data !== expRspD) begin
        errors++; $display("FAIL idle_rsp cycle %0d got %b/%h required %b/%h", k, bus.rsp_valid, bus.rsp_data, expRspV, expRspD); end
      advance();
    end
    for (int i = 0; i < NREQ; i++) begin opA[i] = rand_fp(); opB[i] = rand_fp(); end
    vld = 4'b1111; drive_bus();
    @(negedge clk);
    checks++; if (bus.req_ready !== 4'b0100) begin
      errors++; $display("FAIL idle_ptr_hold got %b required 0100", bus.req_ready); end
    advance(); vld = '0; drive_bus();
    for (int k = 0; k < 4; k++) advance();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i] && $urandom_range(0, 1) == 1) begin
          vld[i] = 1'b1; opA[i] = rand_fp(); opB[i] = rand_fp();
        end
      end
      drive_bus();
      @(negedge clk); compute_expect();
      checks++; if (bus.req_ready !== expReady) begin
        errors++; $display("FAIL rand_grant cycle %0d got %b required %b", k, bus.req_ready, expReady); end
      checks++; if (bus.mul_en !== (expLane >= 0) || bus.mul_a !== expA || bus.mul_b !== expB) begin
        errors++; $display("FAIL rand_issue cycle %0d got %b/%h/%h required %b/%h/%h", k, bus.mul_en, bus.mul_a, bus.mul_b, expLane >= 0, expA, expB); end
      checks++; if (bus.rsp_valid !== expRspV || bus.rsp_data !== expRspD) begin
        errors++; $display("FAIL rand_rsp cycle %0d got %b/%h required %b/%h", k, bus.rsp_valid, bus.rsp_data, expRspV, expRspD); end
      checks++; if (bus.busy !== expBusy) begin
        errors++; $display("FAIL rand_busy cycle %0d got %b required %b", k, bus.busy, expBusy); end
      advance();
      if (expLane >= 0) vld[expLane] = 1'b0;
    end
    rst = 1'b0; vld = '0; drive_bus();
    for (int k = 0; k < 5; k++) advance();
  endtask

  initial begin
    vld = '0;
    for (int i = 0; i < NREQ; i++) begin opA[i] = 16'h0; opB[i] = 16'h0; end
    drive_bus();
    test_reset();
    test_single();
    test_all_contend();
    test_fairness();
    test_stream();
    test_reset_midflight();
    test_idle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
